// File: rtl/bram_porta_arbiter.sv
// Port-A arbiter for the character/attribute BRAM: round-robin between two bus
// requesters, plus a built-in sweep engine that fills every word with one value.
module bram_porta_arbiter #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  r0_req_i,
    input  logic                  r0_we_i,
    input  logic [ADDR_WIDTH-1:0] r0_addr_i,
    input  logic [DATA_WIDTH-1:0] r0_wdata_i,
    output logic                  r0_gnt_o,
    output logic                  r0_rvalid_o,
    output logic [DATA_WIDTH-1:0] r0_rdata_o,

    input  logic                  r1_req_i,
    input  logic                  r1_we_i,
    input  logic [ADDR_WIDTH-1:0] r1_addr_i,
    input  logic [DATA_WIDTH-1:0] r1_wdata_i,
    output logic                  r1_gnt_o,
    output logic                  r1_rvalid_o,
    output logic [DATA_WIDTH-1:0] r1_rdata_o,

    input  logic                  clr_start_i,
    input  logic [DATA_WIDTH-1:0] clr_value_i,
    output logic                  clr_busy_o,
    output logic                  clr_done_o,

    output logic [ADDR_WIDTH-1:0] addra_o,
    output logic                  wea_o,
    output logic [DATA_WIDTH-1:0] dina_o,
    input  logic [DATA_WIDTH-1:0] douta_i
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  last_r1_q, last_r1_d;
    logic                  r0_rvalid_q, r1_rvalid_q;
    logic                  gnt0, gnt1;

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave a value held and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        last_r1_d  = last_r1_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        addra_o    = '0;
        wea_o      = 1'b0;
        dina_o     = '0;
        clr_busy_o = 1'b0;
        clr_done_o = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie, the requester not served last wins.
                if (!rst_i) begin
                    if (r0_req_i && (!r1_req_i || last_r1_q)) gnt0 = 1'b1;
                    else if (r1_req_i)                        gnt1 = 1'b1;
                end
                if (gnt0) begin
                    addra_o   = r0_addr_i;
                    wea_o     = r0_we_i;
                    dina_o    = r0_wdata_i;
                    last_r1_d = 1'b0;
                end else if (gnt1) begin
                    addra_o   = r1_addr_i;
                    wea_o     = r1_we_i;
                    dina_o    = r1_wdata_i;
                    last_r1_d = 1'b1;
                end
                if (clr_start_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    fill_d  = clr_value_i;
                end
            end
            CLEAR: begin
                clr_busy_o = 1'b1;
                wea_o      = 1'b1;
                addra_o    = cnt_q;
                dina_o     = fill_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                clr_done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_q      <= '0;
            last_r1_q   <= 1'b1;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            last_r1_q   <= last_r1_d;
            r0_rvalid_q <= gnt0 && !r0_we_i;
            r1_rvalid_q <= gnt1 && !r1_we_i;
        end
    end

    assign r0_gnt_o    = gnt0;
    assign r1_gnt_o    = gnt1;
    assign r0_rvalid_o = r0_rvalid_q;
    assign r1_rvalid_o = r1_rvalid_q;
    // BRAM read latency is one cycle, so douta_i lines up with the rvalid cycle.
    assign r0_rdata_o  = douta_i;
    assign r1_rdata_o  = douta_i;

endmodule

// File: doc/bram_porta_arbiter.md
Name: bram_porta_arbiter

Overview:
- Shares write/read port A of the dual-port character/attribute BRAM between two bus-side requesters (APB slave, DMA/scroll helper) and a built-in screen-clear engine.
- Port B stays dedicated to the VGA scan-out path and is not touched.
- Round-robin arbitration between requesters; clear engine has exclusive access while active.
- Returns read data with a valid strobe aligned to the BRAM's 1-cycle read latency.

Parameters:
- DATA_WIDTH, 2: BRAM word width; must match the BRAM instance.
- ADDR_WIDTH, 4: BRAM address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk_i  in  1  clock; single domain with the BRAM
- rst_i  in  1  synchronous active-high reset
- r0_req_i  in  1  requester 0 access request; held until granted
- r0_we_i  in  1  requester 0 write (1) / read (0)
- r0_addr_i  in  ADDR_WIDTH  requester 0 address
- r0_wdata_i  in  DATA_WIDTH  requester 0 write data
- r0_gnt_o  out  1  requester 0 grant; combinational, access occurs this cycle
- r0_rvalid_o  out  1  requester 0 read data valid
- r0_rdata_o  out  DATA_WIDTH  requester 0 read data
- r1_*  same seven signals as r0_* for requester 1
- clr_start_i  in  1  start clear sweep (pulse)
- clr_value_i  in  DATA_WIDTH  fill value; sampled on accepted start
- clr_busy_o  out  1  clear sweep in progress
- clr_done_o  out  1  one-cycle pulse after last clear write
- addra_o  out  ADDR_WIDTH  to BRAM addra_i
- wea_o  out  1  to BRAM wea_i
- dina_o  out  DATA_WIDTH  to BRAM dina_i
- douta_i  in  DATA_WIDTH  from BRAM douta_o

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: all gnt/rvalid 0, clr_busy_o 0, clr_done_o 0, wea_o 0, addra_o 0, dina_o 0, clear counter 0, FSM IDLE, RR pointer = "last granted r1" (r0 wins the first tie).
- FSM states: IDLE, CLEAR, DONE.
- IDLE:
  - Arbitration is combinational.
  - Single requester: granted the same cycle.
  - Both requesting: grant the one not granted last; pointer updates only on a grant.
  - At most one gnt per cycle.
  - Granted requester drives addra_o/wea_o/dina_o directly.
  - No grant: wea_o=0, addra_o=0, dina_o=0.
- Read handshake:
  - A granted read (we=0) sets that requester's rvalid_o for exactly the next cycle.
  - rdata_o = douta_i in that cycle; rdata_o is don't-care when rvalid_o=0 (may simply mirror douta_i).
  - Granted writes produce no rvalid.
  - Back-to-back reads yield back-to-back rvalids.
- Requester rules: may change req/we/addr/wdata only after gnt; un-granted requests wait indefinitely; no timeout.
- IDLE -> CLEAR:
  - On clr_start_i=1 in IDLE, latch clr_value_i and clear counter=0.
  - Requester grants in that same cycle still proceed.
  - CLEAR starts next cycle.
- CLEAR:
  - clr_busy_o=1, no grants, wea_o=1, addra_o=counter, dina_o=latched value; counter increments each cycle.
  - After writing address DEPTH-1, go to DONE.
  - Exactly DEPTH write cycles.
  - clr_start_i is ignored in CLEAR and DONE.
- DONE: one cycle; clr_done_o=1, clr_busy_o=0, no grants, wea_o=0; then IDLE.
- Read in flight on entering CLEAR: its rvalid still fires in the first CLEAR cycle with the pre-clear data.
- Counter width: ADDR_WIDTH+1 or terminal compare at DEPTH-1; no wrap past DEPTH-1.
- Reset mid-operation:
  - Aborts the sweep; memory left partially cleared.
  - Pending rvalid dropped; RR pointer reinitialised.
  - No clr_done_o pulse.

Test Plan:
- Reset then idle: rst_i high 2 cycles -> all gnt/rvalid/clr_* outputs 0, wea_o 0, addra_o 0.
- Single write/read: r0 writes 0x2 to addr 5, then reads addr 5 -> r0_gnt_o same cycle each time; r0_rvalid_o high exactly 1 cycle after the read grant with r0_rdata_o=0x2; r1_rvalid_o stays 0.
- Round-robin: r0 and r1 both hold read requests for 4 cycles from reset -> grants r0,r1,r0,r1; each rvalid lands on the correct requester one cycle after its grant.
- Clear sweep: pre-load addr 3=0x1, pulse clr_start_i with clr_value_i=0x3 -> clr_busy_o high for exactly 16 cycles with addresses 0..15 in order and wea_o=1; clr_done_o for 1 cycle; r0 requesting throughout gets gnt only after DONE; reading addr 3 returns 0x3.
- Clear start with pending read: r1 read granted in the same cycle as clr_start_i -> r1_rvalid_o fires in the first CLEAR cycle; sweep unaffected; a second clr_start_i mid-sweep is ignored (still 16 writes).
- Reset mid-clear: assert rst_i at sweep address 7 -> next cycle clr_busy_o=0, no clr_done_o; addr 10 retains its old value; arbitration resumes with r0 priority.
